// File: rtl/nibbler_shift_pkg.sv
// rtl/nibbler_shift_pkg.sv - shared constants and state encoding for the shift sequencer
package nibbler_shift_pkg;

    localparam int C_OFFBITS_DEF  = 3;
    localparam int C_BITSTEP_BITS = 2;
    localparam int C_STATE_BITS   = 3;

    localparam logic [C_STATE_BITS-1:0] S_IDLE  = 3'd0;
    localparam logic [C_STATE_BITS-1:0] S_CLEAR = 3'd1;
    localparam logic [C_STATE_BITS-1:0] S_NIB   = 3'd2;
    localparam logic [C_STATE_BITS-1:0] S_BIT   = 3'd3;
    localparam logic [C_STATE_BITS-1:0] S_DONE  = 3'd4;

endpackage

// File: rtl/param_down_counter.sv
// rtl/param_down_counter.sv - loadable down-counter that saturates at zero
module param_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == W'(1));

endmodule

// File: rtl/param_shift_seq_ctrl.sv
// rtl/param_shift_seq_ctrl.sv - splits a shift amount into nibble-index steps and single-bit steps
module param_shift_seq_ctrl
    import nibbler_shift_pkg::*;
#(
    parameter int C_OFFBITS   = C_OFFBITS_DEF,
    parameter int C_SHAMTBITS = C_OFFBITS + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [C_SHAMTBITS-1:0] req_shamt,
    input  logic                   req_left,
    output logic                   demux_clr,
    output logic                   demux_en,
    output logic                   demux_dir,
    output logic                   bit_en,
    output logic                   bit_dir,
    output logic                   busy,
    output logic                   resp_val,
    input  logic                   resp_rdy
);

    logic [C_STATE_BITS-1:0]   state;
    logic [C_STATE_BITS-1:0]   state_nxt;
    logic                      dir;
    logic                      accept;
    logic [C_OFFBITS-1:0]      nib_cnt;
    logic [C_BITSTEP_BITS-1:0] bit_cnt;
    logic                      nib_zero;
    logic                      nib_one;
    logic                      bit_zero;
    logic                      bit_one;

    assign accept = req_val && req_rdy;

    param_down_counter #(.W(C_OFFBITS)) u_nib_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (req_shamt[C_SHAMTBITS-1:C_BITSTEP_BITS]),
        .dec      (state == S_NIB),
        .count    (nib_cnt),
        .is_zero  (nib_zero),
        .is_one   (nib_one)
    );

    param_down_counter #(.W(C_BITSTEP_BITS)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (req_shamt[C_BITSTEP_BITS-1:0]),
        .dec      (state == S_BIT),
        .count    (bit_cnt),
        .is_zero  (bit_zero),
        .is_one   (bit_one)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = !nib_zero ? S_NIB : (!bit_zero ? S_BIT : S_DONE);
            S_NIB:   if (nib_one) state_nxt = !bit_zero ? S_BIT : S_DONE;
            S_BIT:   if (bit_one) state_nxt = S_DONE;
            S_DONE:  if (resp_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) dir <= req_left;
        end
    end

    // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
    assign req_rdy   = !reset && (state == S_IDLE);
    assign demux_clr = !reset && (state == S_CLEAR);
    assign demux_en  = !reset && (state == S_NIB);
    assign bit_en    = !reset && (state == S_BIT);
    assign resp_val  = !reset && (state == S_DONE);
    assign busy      = !reset && (state != S_IDLE);
    assign demux_dir = demux_en && dir;
    assign bit_dir   = bit_en && dir;

endmodule

// File: tb/tb_param_shift_seq_ctrl.sv
// tb/tb_param_shift_seq_ctrl.sv - scoreboard bench for the shift sequencer
module tb_param_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_val = 1'b0;
    logic       req_rdy;
    logic [4:0] req_shamt = 5'd0;
    logic       req_left = 1'b0;
    logic       demux_clr, demux_en, demux_dir, bit_en, bit_dir, busy, resp_val;
    logic       resp_rdy = 1'b1;

    param_shift_seq_ctrl #(.C_OFFBITS(3), .C_SHAMTBITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_shamt (req_shamt),
        .req_left  (req_left),
        .demux_clr (demux_clr),
        .demux_en  (demux_en),
        .demux_dir (demux_dir),
        .bit_en    (bit_en),
        .bit_dir   (bit_dir),
        .busy      (busy),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nib;
        int bits;
        bit dir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: accumulates what the DUT did since the last accept, compares on first resp_val.
    int acc_cyc, clr_cnt, clr_cyc, nib_cnt, bit_cnt, first_nib, first_bit;
    bit seen_one, seen_zero, resp_seen;

    always @(negedge clk) begin
        if (reset) begin
            resp_seen = 1'b0;
            clr_cnt = 0; nib_cnt = 0; bit_cnt = 0;
        end else begin
            if ((int'(demux_clr) + int'(demux_en) + int'(bit_en)) > 1)
                check("mutex", 1, 0);
            if (!busy && (demux_dir || bit_dir))
                check("idle_dir_zero", {demux_dir, bit_dir}, 0);
            if (demux_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (demux_en) begin
                if (nib_cnt == 0) first_nib = cyc;
                nib_cnt++;
                if (demux_dir) seen_one = 1'b1; else seen_zero = 1'b1;
            end
            if (bit_en) begin
                if (bit_cnt == 0) first_bit = cyc;
                bit_cnt++;
                if (bit_dir) seen_one = 1'b1; else seen_zero = 1'b1;
            end
            if (resp_val && !resp_seen) begin
                resp_seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc - acc_cyc, 2 + e.nib + e.bits);
                    check("clr_pulses", clr_cnt, 1);
                    check("clr_at_t1", clr_cyc - acc_cyc, 1);
                    check("nib_pulses", nib_cnt, e.nib);
                    check("bit_pulses", bit_cnt, e.bits);
                    if (e.nib > 0) check("first_nib", first_nib - acc_cyc, 2);
                    if (e.bits > 0) check("first_bit", first_bit - acc_cyc, 2 + e.nib);
                    if (e.nib + e.bits > 0)
                        check("step_dir", e.dir ? int'(seen_zero) : int'(seen_one), 0);
                end
            end
            if (resp_val && resp_rdy) resp_seen = 1'b0;
            if (req_val && req_rdy) begin
                acc_cyc = cyc;
                clr_cnt = 0; nib_cnt = 0; bit_cnt = 0;
                seen_one = 1'b0; seen_zero = 1'b0;
            end
        end
    end

    // Returns in cycle t+1 after the accept cycle t.
    task automatic issue(input logic [4:0] shamt, input logic left, input bit push);
        bit ok;
        exp_t e;
        ok = 1'b0;
        @(posedge clk); #1;
        req_val = 1'b1; req_shamt = shamt; req_left = left;
        if (push) begin
            e.nib = int'(shamt[4:2]); e.bits = int'(shamt[1:0]); e.dir = left;
            sb.push_back(e);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_val && resp_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              {req_rdy, demux_clr, demux_en, demux_dir, bit_en, bit_dir, busy, resp_val}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_rdy", req_rdy, 1);
        check("idle_busy", busy, 0);

        issue(5'd0, 1'b1, 1'b1);  wait_done();
        issue(5'd9, 1'b1, 1'b1);  wait_done();
        issue(5'd31, 1'b0, 1'b1); wait_done();

        // Backpressure on the response.
        resp_rdy = 1'b0;
        issue(5'd3, 1'b1, 1'b1);
        for (int k = 0; k < 20 && !resp_val; k++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_resp_val", resp_val, 1);
            check("hold_req_rdy", req_rdy, 0);
        end
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        check("hs_req_rdy", req_rdy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_hs_rdy", req_rdy, 1);

        // Abort mid-sequence: no response may appear afterwards.
        issue(5'd20, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs",
              {req_rdy, demux_clr, demux_en, demux_dir, bit_en, bit_dir, busy, resp_val}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", {demux_clr, demux_en, bit_en, busy, resp_val}, 0);
        check("post_rst_rdy", req_rdy, 1);
        repeat (12) @(negedge clk);
        issue(5'd4, 1'b1, 1'b1);  wait_done();

        // Request pulsed while busy and inputs changed after accept.
        issue(5'd22, 1'b1, 1'b1);
        req_shamt = 5'd1; req_left = 1'b0;
        @(posedge clk); #1;
        req_val = 1'b1;
        @(negedge clk);
        check("busy_rdy", req_rdy, 0);
        @(posedge clk); #1;
        req_val = 1'b0;
        wait_done();

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
